// File: rtl/bin2bcd_pkg.sv
// Shared constants and state encoding for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  localparam int unsigned DIG_W   = 4;
  localparam int unsigned N_DIG   = 4;
  localparam int unsigned WORK_W  = DIG_W * N_DIG;
  localparam int unsigned BCD_MAX = 9999;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOp   = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/bin2bcd_if.sv
// Start/done handshake and BCD result bundle between a requester and bin2bcd_seq.
interface bin2bcd_if #(
  parameter int unsigned BIN_W = 14
);
  import bin2bcd_pkg::*;

  logic             start;
  logic [BIN_W-1:0] bin;
  logic             ready;
  logic             done_tick;
  logic             ovf;
  logic [DIG_W-1:0] bcd3;
  logic [DIG_W-1:0] bcd2;
  logic [DIG_W-1:0] bcd1;
  logic [DIG_W-1:0] bcd0;

  modport master (
    output start, bin,
    input  ready, done_tick, ovf, bcd3, bcd2, bcd1, bcd0
  );

  modport slave (
    input  start, bin,
    output ready, done_tick, ovf, bcd3, bcd2, bcd1, bcd0
  );

endinterface

// File: rtl/bcd_adj3.sv
// Combinational add-3 digit correction used before each double-dabble shift.
module bcd_adj3
  import bin2bcd_pkg::*;
(
  input  logic [DIG_W-1:0] digit,
  output logic [DIG_W-1:0] adjusted
);

  // Digits of 5 or more would overflow past 9 when doubled; pre-bias them by 3.
  always_comb begin
    adjusted = (digit >= DIG_W'(5)) ? digit + DIG_W'(3) : digit;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 binary-to-BCD converter feeding a 4-digit display mux.
// Optional build macro BIN2BCD_SAT_EN: saturate the displayed digits to 9999 when the
// captured operand exceeds 9999 (ovf is flagged in both builds).
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned BIN_W = 14
) (
  input logic       clk,
  input logic       reset,
  bin2bcd_if.slave  bus
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIN_W-1:0]  shift_q, shift_d;
  logic [WORK_W-1:0] work_q, work_d;
  logic              ovf_work_q, ovf_work_d;
  logic [WORK_W-1:0] out_q, out_d;
  logic              ovf_q, ovf_d;
  logic [WORK_W-1:0] adj;
  logic              carry_unused;

  for (genvar i = 0; i < N_DIG; i++) begin : g_adj
    bcd_adj3 u_adj (
      .digit    (work_q[i*DIG_W +: DIG_W]),
      .adjusted (adj[i*DIG_W +: DIG_W])
    );
  end

  // Next-state, datapath and output-register loading; outputs change only on DONE entry.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    work_d       = work_q;
    ovf_work_d   = ovf_work_q;
    out_d        = out_q;
    ovf_d        = ovf_q;
    carry_unused = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          shift_d    = bus.bin;
          work_d     = '0;
          cnt_d      = CNT_W'(BIN_W);
          ovf_work_d = (32'(bus.bin) > BCD_MAX);
          state_d    = StOp;
        end
      end
      StOp: begin
        // Carry out of the thousands digit is dropped, giving bin mod 10000.
        {carry_unused, work_d} = {adj, shift_q[BIN_W-1]};
        shift_d = shift_q << 1;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = StDone;
`ifdef BIN2BCD_SAT_EN
          out_d   = ovf_work_q ? 16'h9999 : work_d;
`else
          out_d   = work_d;
`endif
          ovf_d   = ovf_work_q;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      shift_q    <= '0;
      work_q     <= '0;
      ovf_work_q <= 1'b0;
      out_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      work_q     <= work_d;
      ovf_work_q <= ovf_work_d;
      out_q      <= out_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.ready     = (state_q == StIdle);
  assign bus.done_tick = (state_q == StDone);
  assign bus.ovf       = ovf_q;
  assign bus.bcd3      = out_q[15:12];
  assign bus.bcd2      = out_q[11:8];
  assign bus.bcd1      = out_q[7:4];
  assign bus.bcd0      = out_q[3:0];

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: vector table, random vs. arithmetic model,
// and hand-written handshake/reset sequences.
module tb_bin2bcd_seq;

  localparam int unsigned BW = 14;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;
  int   tick_cnt;

  bin2bcd_if #(.BIN_W(BW)) bus ();

  bin2bcd_seq #(.BIN_W(BW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.done_tick) tick_cnt++;

  typedef struct {
    logic [13:0] bin;
    logic [15:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [15:0] bcd_now();
    return {bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0};
  endfunction

  // Expected display value computed with plain decimal arithmetic.
  function automatic logic [15:0] model(input int v);
    int r;
`ifdef BIN2BCD_SAT_EN
    r = (v > 9999) ? 9999 : v;
`else
    r = v % 10000;
`endif
    return {4'(r / 1000), 4'((r / 100) % 10), 4'((r / 10) % 10), 4'(r % 10)};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Launch one conversion and wait (bounded) for done_tick; lat counts the capture edge as 1.
  task automatic run_conv(input logic [13:0] v, output int lat);
    int busy_ready;
    busy_ready = 0;
    lat = -1;
    @(negedge clk);
    bus.bin   = v;
    bus.start = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done_tick) begin
        lat = e;
        break;
      end
      if (bus.ready) busy_ready++;
    end
    check("ready_low_while_busy", busy_ready, 0);
  endtask

  initial begin
    int lat;
    int t0;
    int held_bad;
    int tick_pos[$];
    n_pass    = 0;
    n_total   = 0;
    tick_cnt  = 0;
    bus.start = 1'b0;
    bus.bin   = '0;
    reset     = 1'b0;

    vecs[0] = '{14'd0,     16'h0000, 1'b0};
    vecs[1] = '{14'd1234,  16'h1234, 1'b0};
    vecs[2] = '{14'd9999,  16'h9999, 1'b0};
    vecs[3] = '{14'd5,     16'h0005, 1'b0};
    vecs[4] = '{14'd99,    16'h0099, 1'b0};
`ifdef BIN2BCD_SAT_EN
    vecs[5] = '{14'd12345, 16'h9999, 1'b1};
    vecs[6] = '{14'd10000, 16'h9999, 1'b1};
    vecs[7] = '{14'd16383, 16'h9999, 1'b1};
`else
    vecs[5] = '{14'd12345, 16'h2345, 1'b1};
    vecs[6] = '{14'd10000, 16'h0000, 1'b1};
    vecs[7] = '{14'd16383, 16'h6383, 1'b1};
`endif

    // Reset state.
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_ready", int'(bus.ready), 1);
    check("reset_done_tick", int'(bus.done_tick), 0);
    check("reset_ovf", int'(bus.ovf), 0);
    check("reset_bcd", int'(bcd_now()), 0);

    // Table vectors.
    foreach (vecs[i]) begin
      run_conv(vecs[i].bin, lat);
      check($sformatf("vec%0d_latency", i), lat, 15);
      check($sformatf("vec%0d_bcd", i), int'(bcd_now()), int'(vecs[i].bcd));
      check($sformatf("vec%0d_ovf", i), int'(bus.ovf), int'(vecs[i].ovf));
    end

    // Random operands against the arithmetic model.
    for (int i = 0; i < 20; i++) begin
      int v;
      v = int'($urandom_range(0, 16383));
      run_conv(14'(v), lat);
      check($sformatf("rnd%0d_latency", i), lat, 15);
      check($sformatf("rnd%0d_bcd_%0d", i, v), int'(bcd_now()), int'(model(v)));
      check($sformatf("rnd%0d_ovf", i), int'(bus.ovf), (v > 9999) ? 1 : 0);
    end

    // Start during OP is ignored; prior result held until the single done_tick.
    run_conv(14'd1234, lat);
    @(negedge clk);
    t0 = tick_cnt;
    held_bad = 0;
    bus.bin   = 14'd42;
    bus.start = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      @(negedge clk);
      bus.start = (e == 5);
      if (e == 5) bus.bin = 14'd7777;
      if (e == 6) bus.bin = 14'd7777;
      if (bus.done_tick) break;
      if (bcd_now() != 16'h1234) held_bad++;
    end
    bus.start = 1'b0;
    check("held_until_done", held_bad, 0);
    check("ignored_start_bcd", int'(bcd_now()), int'(16'h0042));
    repeat (40) @(negedge clk);
    check("ignored_start_single_tick", tick_cnt - t0, 1);
    check("ignored_start_held_after", int'(bcd_now()), int'(16'h0042));

    // Start held high: back-to-back conversions, one IDLE cycle between them.
    @(negedge clk);
    bus.bin   = 14'd3;
    bus.start = 1'b1;
    for (int e = 1; e <= 60; e++) begin
      @(negedge clk);
      if (e == 32) bus.start = 1'b0;
      if (bus.done_tick) tick_pos.push_back(e);
    end
    check("b2b_tick_count", tick_pos.size(), 2);
    if (tick_pos.size() == 2) begin
      check("b2b_first_tick", tick_pos[0], 15);
      check("b2b_second_tick", tick_pos[1], 31);
    end
    check("b2b_bcd", int'(bcd_now()), int'(16'h0003));

    // Reset mid-conversion aborts it; a fresh conversion then completes.
    @(negedge clk);
    t0 = tick_cnt;
    bus.bin   = 14'd1234;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("midreset_ready", int'(bus.ready), 1);
    check("midreset_bcd", int'(bcd_now()), 0);
    check("midreset_done_tick", int'(bus.done_tick), 0);
    repeat (20) @(negedge clk);
    check("midreset_no_tick", tick_cnt - t0, 0);
    run_conv(14'd500, lat);
    check("post_reset_latency", lat, 15);
    check("post_reset_bcd", int'(bcd_now()), int'(16'h0500));
    check("post_reset_ovf", int'(bus.ovf), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
